// File: rtl/beat_sequencer.sv
// beat_sequencer: game-flow controller for the piano game.
// Drives the beat timeline, judges each beat and tracks score/misses.
module beat_sequencer #(
  parameter int NUM_STEPS = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_MISS  = 3,
  parameter int BEAT_LAST = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  input  logic              wrong,
  input  logic [5:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [5:0]        check,
  output logic [6:0]        beat_cnt,
  output logic              restart,
  output logic              stop_or_end,
  output logic [6:0]        score,
  output logic [1:0]        miss_cnt,
  output logic [1:0]        state,
  output logic              win
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [6:0] BL      = 7'(BEAT_LAST);
  localparam logic [6:0] BL_M1   = 7'(BEAT_LAST - 1);
  localparam logic [1:0] MM      = 2'(MAX_MISS);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NUM_STEPS - 1);

  logic [1:0]        state_q, state_d;
  logic [6:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        check_q, check_d;
  logic [6:0]        score_q, score_d;
  logic [1:0]        miss_q, miss_d;
  logic              win_q, win_d;
  logic              restart_q, restart_d;
  logic              soe_q, soe_d;
  logic              load_q, load_d;
  logic              judge_q, judge_d;

  logic              judge_act;
  logic              ended;
  logic [1:0]        miss_new;

  assign judge_act = judge_q
                   & ((state_q == S_PLAY)
                   | (state_q == S_PAUSE));
  assign miss_new  = miss_q + {1'b0, wrong};

  // Next-state: start restarts, then beat advance, judge, pause toggle.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    score_d   = score_q;
    miss_d    = miss_q;
    win_d     = win_q;
    restart_d = 1'b0;
    load_d    = 1'b0;
    judge_d   = 1'b0;
    ended     = 1'b0;
    if (start) begin
      state_d   = S_PLAY;
      beat_d    = '0;
      addr_d    = '0;
      score_d   = '0;
      miss_d    = '0;
      win_d     = 1'b0;
      restart_d = 1'b1;
      load_d    = 1'b1;
    end else begin
      if ((state_q == S_PLAY) && tick) begin
        beat_d  = (beat_q == BL) ? 7'd0
                                 : beat_q + 7'd1;
        judge_d = (beat_q == BL_M1);
      end
      if (judge_act) begin
        if (wrong)
          miss_d = miss_new;
        else if (score_q != 7'd127)
          score_d = score_q + 7'd1;
        if (miss_new == MM) begin
          state_d = S_DONE;
          win_d   = 1'b0;
          ended   = 1'b1;
        end else if (addr_q == A_LAST) begin
          state_d = S_DONE;
          win_d   = 1'b1;
          ended   = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
          load_d = 1'b1;
        end
      end
      if (pause && !ended) begin
        unique case (1'b1)
          (state_q == S_PLAY):  state_d = S_PAUSE;
          (state_q == S_PAUSE): state_d = S_PLAY;
          default: ;
        endcase
      end
    end
    soe_d   = (state_d != S_PLAY);
    check_d = load_q ? rom_data : check_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      check_q   <= '0;
      score_q   <= '0;
      miss_q    <= '0;
      win_q     <= 1'b0;
      restart_q <= 1'b0;
      soe_q     <= 1'b1;
      load_q    <= 1'b0;
      judge_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      check_q   <= check_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      win_q     <= win_d;
      restart_q <= restart_d;
      soe_q     <= soe_d;
      load_q    <= load_d;
      judge_q   <= judge_d;
    end
  end

  assign rom_addr    = addr_q;
  assign check       = check_q;
  assign beat_cnt    = beat_q;
  assign restart     = restart_q;
  assign stop_or_end = soe_q;
  assign score       = score_q;
  assign miss_cnt    = miss_q;
  assign state       = state_q;
  assign win         = win_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: scoreboard bench for beat_sequencer.
// Four-step song; expected judge results are queued and popped.
module tb_beat_sequencer;

  localparam int NS = 4;

  logic       clk = 1'b0;
  bit         clk_en = 1'b1;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic       wrong = 1'b0;
  logic [5:0] rom_data;
  logic [4:0] rom_addr;
  logic [5:0] check;
  logic [6:0] beat_cnt;
  logic       restart;
  logic       stop_or_end;
  logic [6:0] score;
  logic [1:0] miss_cnt;
  logic [1:0] state;
  logic       win;

  logic [5:0] pat [0:31];

  typedef struct {
    int score;
    int miss;
    int addr;
    int st;
    int win;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int e_score, e_miss, e_addr, e_st, e_win, e_beat;

  beat_sequencer #(
    .NUM_STEPS(NS),
    .ADDR_W(5),
    .MAX_MISS(3),
    .BEAT_LAST(96)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .tick(tick),
    .wrong(wrong),
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .check(check),
    .beat_cnt(beat_cnt),
    .restart(restart),
    .stop_or_end(stop_or_end),
    .score(score),
    .miss_cnt(miss_cnt),
    .state(state),
    .win(win)
  );

  always #5 if (clk_en) clk = ~clk;

  assign rom_data = pat[rom_addr];

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_state"}, int'(state), 0);
    chk({p, "_beat"}, int'(beat_cnt), 0);
    chk({p, "_addr"}, int'(rom_addr), 0);
    chk({p, "_check"}, int'(check), 0);
    chk({p, "_score"}, int'(score), 0);
    chk({p, "_miss"}, int'(miss_cnt), 0);
    chk({p, "_win"}, int'(win), 0);
    chk({p, "_restart"}, int'(restart), 0);
    chk({p, "_soe"}, int'(stop_or_end), 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    e_score = 0; e_miss = 0; e_addr = 0;
    e_st = 1; e_win = 0; e_beat = 0;
    chk("st_restart1", int'(restart), 1);
    chk("st_state", int'(state), 1);
    chk("st_soe", int'(stop_or_end), 0);
    chk("st_score", int'(score), 0);
    chk("st_miss", int'(miss_cnt), 0);
    chk("st_beat", int'(beat_cnt), 0);
    chk("st_addr", int'(rom_addr), 0);
    cyc();
    chk("st_restart0", int'(restart), 0);
    chk("st_check", int'(check), int'(pat[0]));
  endtask

  task automatic tick_once(input bit adv);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    if (adv) e_beat = (e_beat == 96) ? 0 : e_beat + 1;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  task automatic play_beat(input bit w);
    exp_t e;
    wrong = w;
    do tick_once(1'b1); while (e_beat != 96);
    chk("pb_beat96", int'(beat_cnt), 96);
    if (w) e_miss++;
    else e_score++;
    if (e_miss == 3) begin
      e_st = 3; e_win = 0;
    end else if (e_addr == NS - 1) begin
      e_st = 3; e_win = 1;
    end else begin
      e_addr++;
    end
    e = '{e_score, e_miss, e_addr, e_st, e_win};
    sbq.push_back(e);
    cyc();
    wrong = 1'b0;
    e = sbq.pop_front();
    chk("j_score", int'(score), e.score);
    chk("j_miss", int'(miss_cnt), e.miss);
    chk("j_addr", int'(rom_addr), e.addr);
    chk("j_state", int'(state), e.st);
    chk("j_soe", int'(stop_or_end),
        (e.st == 1) ? 0 : 1);
    if (e.st == 3) begin
      chk("j_win", int'(win), e.win);
    end else begin
      cyc();
      chk("j_check", int'(check), int'(pat[e.addr]));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      pat[i] = 6'((i * 7 + 3) % 64);

    repeat (2) cyc();
    chk_reset("rst");
    rst_n = 1'b1;
    cyc();

    do_start();

    play_beat(1'b0);
    tick_once(1'b1);
    chk("wrap_beat0", int'(beat_cnt), 0);
    play_beat(1'b0);
    play_beat(1'b0);
    play_beat(1'b0);
    chk("win_score4", int'(score), 4);
    repeat (3) tick_once(1'b0);
    chk("win_frozen", int'(beat_cnt), 96);

    do_start();
    repeat (40) tick_once(1'b1);
    chk("pz_beat40", int'(beat_cnt), 40);
    pulse_pause();
    chk("pz_state2", int'(state), 2);
    chk("pz_soe1", int'(stop_or_end), 1);
    repeat (10) tick_once(1'b0);
    chk("pz_hold", int'(beat_cnt), 40);
    pulse_pause();
    chk("pz_resume", int'(state), 1);
    chk("pz_beat", int'(beat_cnt), 40);
    chk("pz_soe0", int'(stop_or_end), 0);

    play_beat(1'b1);
    play_beat(1'b1);
    play_beat(1'b1);
    repeat (5) tick_once(1'b0);
    chk("loss_beat", int'(beat_cnt), 96);
    chk("loss_state", int'(state), 3);

    do_start();
    play_beat(1'b0);
    repeat (5) tick_once(1'b1);
    pulse_pause();
    chk("ps_state2", int'(state), 2);
    chk("ps_score1", int'(score), 1);
    do_start();

    play_beat(1'b0);
    repeat (3) tick_once(1'b1);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    #2;
    rst_n = 1'b1;
    clk_en = 1'b1;
    cyc();
    chk("post_idle", int'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Game-flow controller for the piano game. It generates the beat timeline (`beat_cnt`) and the freeze/clear controls (`stop_or_end`, `restart`) for the per-beat key-press counter. For each beat it fetches the expected press count (`check`) from the song-pattern ROM. At every beat boundary it samples the counter's `wrong` flag, then updates score and misses and decides win or loss. It sits between the button/tick front end, the pattern ROM, the key-press counter and the display logic.

## Interface
- `NUM_STEPS`, 32: beats per song; judged steps 0..NUM_STEPS-1.
- `ADDR_W`, 5: ROM address width; 2^ADDR_W ≥ NUM_STEPS.
- `MAX_MISS`, 3: miss count that ends the game as a loss; range 1..3.
- `BEAT_LAST`, 96: terminal `beat_cnt` value; the counter clears at this value.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: debounced one-cycle pulse that starts or restarts a game.
- `pause` in 1: debounced one-cycle pulse that toggles between PLAY and PAUSE.
- `tick` in 1: one-cycle beat-subdivision strobe.
- `wrong` in 1: mismatch flag from the key-press counter.
- `rom_data` in 6: expected press count, valid 1 cycle after `rom_addr`.
- `rom_addr` out ADDR_W: current step index.
- `check` out 6: registered expected count for the current step.
- `beat_cnt` out 7: position within the beat, 0..BEAT_LAST.
- `restart` out 1: one-cycle counter-clear pulse.
- `stop_or_end` out 1: freezes the counter.
- `score` out 7: number of correctly judged beats.
- `miss_cnt` out 2: number of wrong beats.
- `state` out 2: IDLE=0, PLAY=1, PAUSE=2, DONE=3.
- `win` out 1: valid in DONE only.

## Operation
- **Reset values.** state IDLE; `beat_cnt`, `rom_addr`, `check`, `score`, `miss_cnt`, `win` and `restart` all 0; `stop_or_end` 1.
- **`stop_or_end`.** Equals 1 in IDLE, PAUSE and DONE; 0 in PLAY. It is a registered output, decoded from the next state.
- **IDLE/DONE + `start`.**
  - Next state PLAY, with `restart`=1 for exactly that edge's following cycle.
  - Clears `beat_cnt`, `rom_addr`, `score`, `miss_cnt` and `win`.
  - Sets a load-pending flag so `check` is loaded from `rom_data` one cycle later.
- **PLAY.**
  - Each `tick` advances `beat_cnt`, wrapping BEAT_LAST→0.
  - When `beat_cnt` goes from BEAT_LAST-1 to BEAT_LAST, a judge strobe fires on the next cycle. This is the only cycle in which the counter still holds the beat's total.
- **Judge cycle.**
  - If `wrong`=1: `miss_cnt`+1. Otherwise: `score`+1.
  - If the new `miss_cnt` equals MAX_MISS: go to DONE with `win`=0.
  - Else if `rom_addr` equals NUM_STEPS-1: go to DONE with `win`=1.
  - Otherwise: `rom_addr`+1, and `check` is reloaded from `rom_data` on the following cycle.
- **PLAY + `start`.** Same as the start action from IDLE (full restart).
- **PLAY + `pause`.** Go to PAUSE. In PAUSE, `tick` is ignored and `beat_cnt` holds.
- **PAUSE.**
  - `pause` returns to PLAY with no reload.
  - `start` performs a restart.
- **Simultaneous events.**
  - `start` has priority over `pause`.
  - A judge strobe coinciding with `pause` is processed first; pause then applies in the same transition unless the judge ends the game (DONE wins).
- **Width rules.** `score` and `miss_cnt` never wrap: `score` ≤ NUM_STEPS ≤ 127, and `miss_cnt` stops at MAX_MISS.

## Timing
- `restart` is high for 1 cycle. `check` is valid 2 cycles after the `start` pulse, well before the first judge.
- Judge latency: 1 cycle after `beat_cnt` reaches BEAT_LAST.
- The `rom_addr` increment and the `check` update happen 1 and 2 cycles after the judge.
- The transition to DONE takes effect on the judge cycle's edge; `stop_or_end` rises in the same cycle the state reads DONE.
- Asserting `rst_n` mid-game returns all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset, then `start`:** state=1, `restart` high 1 cycle, `stop_or_end`=0. With `rom_data`=3 at addr 0, `check`=3 by cycle+2.
- **97 ticks with `wrong`=0 at the judge:** `score`=1, `rom_addr`=1, `beat_cnt`=0 after the 97th tick.
- **`wrong`=1 at three judges (MAX_MISS=3):** `miss_cnt`=3, state=3, `win`=0, `stop_or_end`=1, and further ticks leave `beat_cnt` unchanged.
- **NUM_STEPS=4 with all judges correct:** state=3, `win`=1, `score`=4.
- **`pause` at `beat_cnt`=40, 10 ticks, then `pause`:** `beat_cnt` is still 40 on resume. `start` during PAUSE produces `restart`=1 and clears `score`.
- **`rst_n` low mid-PLAY with no clock running:** all outputs return to reset values immediately; `stop_or_end`=1.
